mu0_mem_arbiter: RTL and testbench
==================================

# mu0_mem_arbiter

Shared-memory arbiter sitting between the MU0 core's memory port and a debug/loader port, both contending for one single-ported synchronous memory. Grants one requester at a time, drives the memory for a parameterised number of wait states, returns read data and a one-cycle acknowledge, and stalls the loser until its turn. Instantiated at the MU0 top level alongside the core and memory.

## Interface
- ADDR_W, 12: address width of both requesters and the memory.
- DATA_W, 16: data width.
- WAIT_STATES, 1: extra memory cycles per access; legal range 0–7.

- Clk  input  1  system clock, all state updates on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- core_req  input  1  core access request; held until core_ack.
- core_wr  input  1  1 = write, 0 = read.
- core_addr  input  ADDR_W  core address.
- core_wdata  input  DATA_W  core write data.
- core_rdata  output  DATA_W  registered read data for core.
- core_ack  output  1  one-cycle completion pulse to core.
- dbg_req, dbg_wr, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same widths, directions and meanings for the debug port.
- mem_cs  output  1  memory chip select.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid in final ACCESS cycle.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if no req, stay. If one req, grant it. If both, grant the port not granted last (round-robin); after reset the core wins the first tie. On grant, latch winner's wr/addr/wdata, record owner, load counter with WAIT_STATES, go to ACCESS.
- ACCESS: mem_cs=1; mem_we=latched wr; mem_addr/mem_wdata from latched registers. Each edge: counter≠0 → decrement; counter=0 → on read, capture mem_rdata into owner's rdata register; go to DONE.
- DONE: owner's ack=1 for exactly one cycle; mem_cs=0; next edge → IDLE. Requests are not sampled in DONE.
- rdata registers change only on completion of a read by that port; writes and the other port's accesses leave them unchanged.
- Requester contract: hold req and fields stable until ack; deassert req the cycle after ack unless issuing a new access. Fields are latched at grant, so later changes do not affect the access in flight.
- Request dropped before ack: in-flight access still completes and acks; ack is ignored by requester.
- Non-owner's req held throughout is served on the next IDLE cycle.

## Timing
- Reset (nReset=0, asynchronous, any state including mid-ACCESS): state IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, core_ack=0, dbg_ack=0, core_rdata=0, dbg_rdata=0, busy=0, round-robin pointer = core-first. Aborted access is not acknowledged.
- Grant edge E0 (IDLE with req): ACCESS occupies WAIT_STATES+1 cycles, DONE 1 cycle, then IDLE 1 cycle.
- Request-to-ack latency: ack high in cycle WAIT_STATES+2 after E0; rdata valid in same cycle and held thereafter.
- Throughput: one access per WAIT_STATES+3 cycles under continuous contention.
- mem_* outputs are registered; no combinational path from any req to mem_cs.

## Configuration
- MU0_ARB_FIXED_PRIO_EN defined: fixed priority, debug port always wins a tie; round-robin pointer not implemented. Core can be starved by a saturating debug port.
- Undefined (default): round-robin arbitration as described in Operation.

## Test plan
- Reset: nReset=0 mid-ACCESS of a core write to 0x010 -> mem_cs/mem_we drop immediately, no core_ack, all outputs 0, busy=0.
- Single read, WAIT_STATES=1: core_req read 0x005, memory holds 0x1234 -> mem_cs high 2 cycles, core_ack in cycle 3 after grant, core_rdata=0x1234.
- Single write, WAIT_STATES=0: dbg write 0xABCD to 0x0FF -> mem_we=1 with mem_addr=0x0FF, mem_wdata=0xABCD for 1 cycle; dbg_ack 2 cycles after grant; dbg_rdata unchanged.
- Tie after reset: core and dbg both request reads at same edge -> core served first, dbg granted on the IDLE cycle after core_ack; next tie grants core again (alternation verified over 4 back-to-back ties).
- Field change after grant: core_addr changes 0x020→0x030 during ACCESS -> mem_addr stays 0x020.
- With MU0_ARB_FIXED_PRIO_EN: repeated simultaneous requests -> dbg granted every tie; core served only when dbg_req=0.

Source files
------------

// File: rtl/mu0_mem_arbiter.sv
// rtl/mu0_mem_arbiter.sv - MU0 core / debug port arbiter for one single-ported synchronous memory
// Optional feature macro: MU0_ARB_FIXED_PRIO_EN (debug port wins every tie; no round-robin pointer)
module mu0_mem_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              core_req,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_dbg_q, owner_dbg_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              core_ack_q, core_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              busy_q, busy_d;
  logic              grant_dbg;
`ifndef MU0_ARB_FIXED_PRIO_EN
  // Set when the debug port held the last grant; reset value lets the core win the first tie.
  logic              last_dbg_q, last_dbg_d;
`endif

  // Next-state logic: arbitrate in IDLE, count wait states in ACCESS, pulse ack in DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_dbg_d  = owner_dbg_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    core_ack_d   = 1'b0;
    dbg_ack_d    = 1'b0;
    grant_dbg    = 1'b0;
`ifndef MU0_ARB_FIXED_PRIO_EN
    last_dbg_d   = last_dbg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (core_req || dbg_req) begin
`ifdef MU0_ARB_FIXED_PRIO_EN
          grant_dbg  = dbg_req;
`else
          grant_dbg  = dbg_req && (!core_req || !last_dbg_q);
          last_dbg_d = grant_dbg;
`endif
          owner_dbg_d = grant_dbg;
          mem_cs_d    = 1'b1;
          mem_we_d    = grant_dbg ? dbg_wr    : core_wr;
          mem_addr_d  = grant_dbg ? dbg_addr  : core_addr;
          mem_wdata_d = grant_dbg ? dbg_wdata : core_wdata;
          cnt_d       = WS_INIT;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          // mem_we_q still holds the latched direction on this final edge.
          if (!mem_we_q) begin
            if (owner_dbg_q) dbg_rdata_d  = mem_rdata;
            else             core_rdata_d = mem_rdata;
          end
          core_ack_d = !owner_dbg_q;
          dbg_ack_d  = owner_dbg_q;
          mem_cs_d   = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; asynchronous reset aborts any access without an ack.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      owner_dbg_q  <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
      core_ack_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifndef MU0_ARB_FIXED_PRIO_EN
      last_dbg_q   <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_dbg_q  <= owner_dbg_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      core_ack_q   <= core_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      busy_q       <= busy_d;
`ifndef MU0_ARB_FIXED_PRIO_EN
      last_dbg_q   <= last_dbg_d;
`endif
    end
  end

  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign core_ack   = core_ack_q;
  assign dbg_ack    = dbg_ack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// tb/tb_mu0_mem_arbiter.sv - directed self-checking bench for mu0_mem_arbiter
module tb_mu0_mem_arbiter;

  localparam int WS = 1;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        core_req, core_wr, dbg_req, dbg_wr;
  logic [11:0] core_addr, dbg_addr, mem_addr;
  logic [15:0] core_wdata, dbg_wdata, core_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        core_ack, dbg_ack, mem_cs, mem_we, busy;

  int checks   = 0;
  int failures = 0;

  mu0_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(WS)) u_dut (
    .Clk(Clk), .nReset(nReset),
    .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory content: 0x005 holds 0x1234, every other word reads as {4'hC, addr}.
  assign mem_rdata = (mem_addr == 12'h005) ? 16'h1234 : {4'hC, mem_addr};

  initial forever #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int cyc, output logic got_core, output logic got_dbg);
    logic seen;
    seen = 1'b0;
    cyc = 0;
    got_core = 1'b0;
    got_dbg = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge Clk);
      cyc++;
      if (core_ack || dbg_ack) begin
        seen = 1'b1;
        got_core = core_ack;
        got_dbg = dbg_ack;
      end
    end
    chk("ack_timeout", {31'd0, seen}, 32'd1);
  endtask

  int   cyc;
  logic gc, gd;
  logic exp_dbg;

  initial begin
    nReset = 1'b0;
    core_req = 0; core_wr = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (2) @(negedge Clk);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_acks", {core_ack, dbg_ack}, 0);
    nReset = 1'b1;
    @(negedge Clk);

    // Single core read of 0x005.
    core_req = 1; core_wr = 0; core_addr = 12'h005;
    @(negedge Clk);
    chk("rd_cs_c1", mem_cs, 1);
    chk("rd_addr_c1", mem_addr, 12'h005);
    chk("rd_busy_c1", busy, 1);
    @(negedge Clk);
    chk("rd_cs_c2", mem_cs, 1);
    chk("rd_ack_c2", core_ack, 0);
    @(negedge Clk);
    chk("rd_ack_c3", core_ack, 1);
    chk("rd_cs_c3", mem_cs, 0);
    chk("rd_rdata", core_rdata, 16'h1234);
    core_req = 0;
    @(negedge Clk);
    chk("rd_ack_drop", core_ack, 0);
    chk("rd_busy_idle", busy, 0);
    chk("rd_rdata_hold", core_rdata, 16'h1234);
    chk("rd_dbg_rdata", dbg_rdata, 0);

    // Debug write 0xABCD to 0x0FF.
    dbg_req = 1; dbg_wr = 1; dbg_addr = 12'h0FF; dbg_wdata = 16'hABCD;
    @(negedge Clk);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 12'h0FF);
    chk("wr_wdata", mem_wdata, 16'hABCD);
    @(negedge Clk);
    chk("wr_cs_c2", mem_cs, 1);
    @(negedge Clk);
    chk("wr_ack", dbg_ack, 1);
    chk("wr_core_ack", core_ack, 0);
    chk("wr_we_done", mem_we, 0);
    chk("wr_dbg_rdata", dbg_rdata, 0);
    chk("wr_core_rdata", core_rdata, 16'h1234);
    dbg_req = 0; dbg_wr = 0;
    @(negedge Clk);

    // Core read of 0x020, address changes during ACCESS.
    core_req = 1; core_wr = 0; core_addr = 12'h020;
    @(negedge Clk);
    core_addr = 12'h030;
    @(negedge Clk);
    chk("fc_addr", mem_addr, 12'h020);
    @(negedge Clk);
    chk("fc_ack", core_ack, 1);
    chk("fc_rdata", core_rdata, 16'hC020);
    core_req = 0;
    @(negedge Clk);

    // Core write to 0x010 aborted by reset mid-ACCESS.
    core_req = 1; core_wr = 1; core_addr = 12'h010; core_wdata = 16'h5A5A;
    @(negedge Clk);
    chk("ab_cs", mem_cs, 1);
    chk("ab_we", mem_we, 1);
    #2 nReset = 1'b0;
    #1;
    chk("ab_cs_rst", mem_cs, 0);
    chk("ab_we_rst", mem_we, 0);
    chk("ab_addr_rst", mem_addr, 0);
    chk("ab_wdata_rst", mem_wdata, 0);
    chk("ab_busy_rst", busy, 0);
    chk("ab_rdata_rst", {core_rdata, dbg_rdata}, 0);
    core_req = 0; core_wr = 0;
    repeat (3) @(negedge Clk);
    chk("ab_no_ack", {core_ack, dbg_ack}, 0);
    nReset = 1'b1;
    @(negedge Clk);

    // Four back-to-back ties with both requests held high.
    core_req = 1; core_addr = 12'h100;
    dbg_req = 1; dbg_addr = 12'h200;
    for (int i = 0; i < 4; i++) begin
`ifdef MU0_ARB_FIXED_PRIO_EN
      exp_dbg = 1'b1;
`else
      exp_dbg = (i % 2) == 1;
`endif
      wait_ack(cyc, gc, gd);
      chk($sformatf("tie%0d_latency", i), cyc, (i == 0) ? WS + 2 : WS + 3);
      chk($sformatf("tie%0d_winner", i), {gc, gd}, {~exp_dbg, exp_dbg});
      if (exp_dbg) chk($sformatf("tie%0d_rdata", i), dbg_rdata, 16'hC200);
      else         chk($sformatf("tie%0d_rdata", i), core_rdata, 16'hC100);
    end

    // Debug stops requesting: core must be served next.
    dbg_req = 0;
    wait_ack(cyc, gc, gd);
    chk("solo_core_latency", cyc, WS + 3);
    chk("solo_core_winner", {gc, gd}, 2'b10);
    core_req = 0;
    repeat (2) @(negedge Clk);
    chk("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
